// File: rtl/amci_arbiter.sv
// rtl/amci_arbiter.sv - two-client round-robin arbiter in front of a single AXI master engine
// Holds one request per client and keeps exactly one engine transaction in flight.
module amci_arbiter #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                      M_AXI_ACLK,
  input  logic                      M_AXI_ARESET,

  input  logic                      c0_start,
  input  logic                      c0_rw,
  input  logic [AXI_ADDR_WIDTH-1:0] c0_addr,
  input  logic [AXI_DATA_WIDTH-1:0] c0_wdata,
  output logic                      c0_busy,
  output logic                      c0_done,
  output logic [AXI_DATA_WIDTH-1:0] c0_rdata,
  output logic [1:0]                c0_resp,

  input  logic                      c1_start,
  input  logic                      c1_rw,
  input  logic [AXI_ADDR_WIDTH-1:0] c1_addr,
  input  logic [AXI_DATA_WIDTH-1:0] c1_wdata,
  output logic                      c1_busy,
  output logic                      c1_done,
  output logic [AXI_DATA_WIDTH-1:0] c1_rdata,
  output logic [1:0]                c1_resp,

  output logic [AXI_ADDR_WIDTH-1:0] amci_waddr,
  output logic [AXI_DATA_WIDTH-1:0] amci_wdata,
  output logic                      amci_write,
  output logic [AXI_ADDR_WIDTH-1:0] amci_raddr,
  output logic                      amci_read,
  input  logic                      amci_widle,
  input  logic                      amci_ridle,
  input  logic [1:0]                amci_wresp,
  input  logic [1:0]                amci_rresp,
  input  logic [AXI_DATA_WIDTH-1:0] amci_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [1:0]                pend;
  logic [1:0]                req_rw;
  logic [AXI_ADDR_WIDTH-1:0] req_addr  [2];
  logic [AXI_DATA_WIDTH-1:0] req_wdata [2];

  logic       last_grant;
  logic       sel;
  logic       sel_rw;
  logic       grant_en;
  logic       grant_id;
  logic       finish;
  logic       eng_idle;
  logic [1:0] fin_resp;

  // busy is simply the pending flag: it clears on the same edge that raises done
  assign c0_busy  = pend[0];
  assign c1_busy  = pend[1];
  assign eng_idle = sel_rw ? amci_widle : amci_ridle;
  assign fin_resp = sel_rw ? amci_wresp : amci_rresp;

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    grant_en = 1'b0;
    grant_id = last_grant;
    finish   = 1'b0;
    unique case (state)
      IDLE: begin
        if (|pend) begin
          grant_en = 1'b1;
          // on a tie the client not served last wins; otherwise the lone requester
          grant_id = (&pend) ? ~last_grant : pend[1];
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        state_nx = WAIT;
      end
      WAIT: begin
        if (eng_idle) begin
          finish   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      pend         <= '0;
      req_rw       <= '0;
      req_addr[0]  <= '0;
      req_addr[1]  <= '0;
      req_wdata[0] <= '0;
      req_wdata[1] <= '0;
    end else begin
      if (c0_start && !pend[0]) begin
        pend[0]      <= 1'b1;
        req_rw[0]    <= c0_rw;
        req_addr[0]  <= c0_addr;
        req_wdata[0] <= c0_wdata;
      end
      if (c1_start && !pend[1]) begin
        pend[1]      <= 1'b1;
        req_rw[1]    <= c1_rw;
        req_addr[1]  <= c1_addr;
        req_wdata[1] <= c1_wdata;
      end
      // finish only fires for a pending client, so it never collides with a load above
      if (finish) begin
        pend[sel] <= 1'b0;
      end
    end
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      amci_write <= 1'b0;
      amci_read  <= 1'b0;
      amci_waddr <= '0;
      amci_wdata <= '0;
      amci_raddr <= '0;
      last_grant <= 1'b1;
      sel        <= 1'b0;
      sel_rw     <= 1'b0;
    end else begin
      amci_write <= 1'b0;
      amci_read  <= 1'b0;
      if (grant_en) begin
        sel        <= grant_id;
        sel_rw     <= req_rw[grant_id];
        last_grant <= grant_id;
        if (req_rw[grant_id]) begin
          amci_write <= 1'b1;
          amci_waddr <= req_addr[grant_id];
          amci_wdata <= req_wdata[grant_id];
        end else begin
          amci_read  <= 1'b1;
          amci_raddr <= req_addr[grant_id];
        end
      end
    end
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      c0_done  <= 1'b0;
      c1_done  <= 1'b0;
      c0_rdata <= '0;
      c1_rdata <= '0;
      c0_resp  <= '0;
      c1_resp  <= '0;
    end else begin
      c0_done <= 1'b0;
      c1_done <= 1'b0;
      if (finish) begin
        if (!sel) begin
          c0_done <= 1'b1;
          c0_resp <= fin_resp;
          if (!sel_rw) begin
            c0_rdata <= amci_rdata;
          end
        end else begin
          c1_done <= 1'b1;
          c1_resp <= fin_resp;
          if (!sel_rw) begin
            c1_rdata <= amci_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_amci_arbiter.sv
// tb/tb_amci_arbiter.sv - directed and randomized bench for amci_arbiter with a behavioural engine
module tb_amci_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          c0_start, c0_rw, c0_busy, c0_done;
  logic [AW-1:0] c0_addr;
  logic [DW-1:0] c0_wdata, c0_rdata;
  logic [1:0]    c0_resp;
  logic          c1_start, c1_rw, c1_busy, c1_done;
  logic [AW-1:0] c1_addr;
  logic [DW-1:0] c1_wdata, c1_rdata;
  logic [1:0]    c1_resp;
  logic [AW-1:0] amci_waddr, amci_raddr;
  logic [DW-1:0] amci_wdata;
  logic          amci_write, amci_read, amci_widle, amci_ridle;
  logic [1:0]    amci_wresp = 2'b0;
  logic [1:0]    amci_rresp = 2'b0;
  logic [DW-1:0] amci_rdata = '0;

  amci_arbiter #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .c0_start(c0_start), .c0_rw(c0_rw), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_busy(c0_busy), .c0_done(c0_done), .c0_rdata(c0_rdata), .c0_resp(c0_resp),
    .c1_start(c1_start), .c1_rw(c1_rw), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_busy(c1_busy), .c1_done(c1_done), .c1_rdata(c1_rdata), .c1_resp(c1_resp),
    .amci_waddr(amci_waddr), .amci_wdata(amci_wdata), .amci_write(amci_write),
    .amci_raddr(amci_raddr), .amci_read(amci_read),
    .amci_widle(amci_widle), .amci_ridle(amci_ridle),
    .amci_wresp(amci_wresp), .amci_rresp(amci_rresp), .amci_rdata(amci_rdata)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Engine model: busy for eng_lat cycles after each start pulse, logs every transaction
  int            eng_lat = 2;
  int            wcnt = 0;
  int            rcnt = 0;
  logic [1:0]    nx_wresp = 2'b0;
  logic [1:0]    nx_rresp = 2'b0;
  logic [DW-1:0] nx_rdata = '0;
  logic          overlap = 1'b0;
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];
  logic          log_rw[$];

  assign amci_widle = !amci_write && (wcnt == 0);
  assign amci_ridle = !amci_read && (rcnt == 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= 0;
      rcnt <= 0;
    end else begin
      if ((amci_write || amci_read) && ((amci_write && amci_read) || wcnt != 0 || rcnt != 0))
        overlap <= 1'b1;
      if (amci_write) begin
        wcnt       <= eng_lat;
        amci_wresp <= nx_wresp;
        log_addr.push_back(amci_waddr);
        log_data.push_back(amci_wdata);
        log_rw.push_back(1'b1);
      end else if (wcnt > 0) begin
        wcnt <= wcnt - 1;
      end
      if (amci_read) begin
        rcnt       <= eng_lat;
        amci_rresp <= nx_rresp;
        amci_rdata <= nx_rdata;
        log_addr.push_back(amci_raddr);
        log_data.push_back('0);
        log_rw.push_back(1'b0);
      end else if (rcnt > 0) begin
        rcnt <= rcnt - 1;
      end
    end
  end

  int dc0 = 0;
  int dc1 = 0;
  always @(negedge clk) begin
    if (c0_done === 1'b1) dc0++;
    if (c1_done === 1'b1) dc1++;
  end

  // Transaction-level reference: per-client request state and round-robin memory
  // st: 0 free, 1 accepted on the last edge, 2 waiting for grant, 3 in service
  int            st[2];
  logic          m_rw[2];
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_wd[2];
  logic [DW-1:0] m_rdata[2];
  logic [1:0]    m_resp[2];
  int            m_last;
  int            m_svc;

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_c0_busy"}, c0_busy, 0);
    chk({tag, "_c1_busy"}, c1_busy, 0);
    chk({tag, "_c0_done"}, c0_done, 0);
    chk({tag, "_c1_done"}, c1_done, 0);
    chk({tag, "_c0_rdata"}, c0_rdata, 0);
    chk({tag, "_c1_rdata"}, c1_rdata, 0);
    chk({tag, "_c0_resp"}, c0_resp, 0);
    chk({tag, "_c1_resp"}, c1_resp, 0);
    chk({tag, "_write"}, amci_write, 0);
    chk({tag, "_read"}, amci_read, 0);
    chk({tag, "_waddr"}, amci_waddr, 0);
    chk({tag, "_wdata"}, amci_wdata, 0);
    chk({tag, "_raddr"}, amci_raddr, 0);
  endtask

  task automatic drive_start(input int n, input logic rw, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    if (n == 0) begin
      c0_start = 1'b1; c0_rw = rw; c0_addr = a; c0_wdata = d;
    end else begin
      c1_start = 1'b1; c1_rw = rw; c1_addr = a; c1_wdata = d;
    end
    @(negedge clk);
    c0_start = 1'b0;
    c1_start = 1'b0;
  endtask

  task automatic wait_done(input int n, input string tag);
    int k = 0;
    while (((n == 0) ? c0_done : c1_done) !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_timeout"}, k < 40, 1);
  endtask

  task automatic wait_counts(input int t0, input int t1, input string tag);
    int k = 0;
    while ((dc0 < t0 || dc1 < t1) && k < 80) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk({tag, "_timeout"}, k < 80, 1);
  endtask

  task automatic model_step(input bit allow);
    logic [1:0] dn, bz;
    logic       s, rw;
    logic [31:0] a, d;
    int g;
    @(negedge clk);
    #1;
    dn = {c1_done, c0_done};
    bz = {c1_busy, c0_busy};
    for (int n = 0; n < 2; n++) begin
      if (dn[n]) begin
        chk("rnd_done_owner", (m_svc == n) && (st[n] == 3), 1);
        if (!m_rw[n]) m_rdata[n] = amci_rdata;
        m_resp[n] = m_rw[n] ? amci_wresp : amci_rresp;
        st[n] = 0;
        m_svc = -1;
      end
    end
    if (amci_write || amci_read) begin
      if (st[0] == 2 && st[1] == 2) g = 1 - m_last;
      else if (st[0] == 2) g = 0;
      else if (st[1] == 2) g = 1;
      else g = -1;
      chk("rnd_grant_exists", g >= 0, 1);
      chk("rnd_single_outstanding", m_svc == -1, 1);
      if (g >= 0) begin
        chk("rnd_op", {amci_write, amci_read}, m_rw[g] ? 2'b10 : 2'b01);
        chk("rnd_addr", m_rw[g] ? amci_waddr : amci_raddr, m_addr[g]);
        if (m_rw[g]) chk("rnd_wdata", amci_wdata, m_wd[g]);
        st[g] = 3;
        m_last = g;
        m_svc = g;
      end
    end
    chk("rnd_c0_busy", bz[0], st[0] != 0);
    chk("rnd_c1_busy", bz[1], st[1] != 0);
    chk("rnd_c0_rdata", c0_rdata, m_rdata[0]);
    chk("rnd_c1_rdata", c1_rdata, m_rdata[1]);
    chk("rnd_c0_resp", c0_resp, m_resp[0]);
    chk("rnd_c1_resp", c1_resp, m_resp[1]);
    for (int n = 0; n < 2; n++) if (st[n] == 1) st[n] = 2;
    for (int n = 0; n < 2; n++) begin
      s  = allow && ($urandom_range(0, 2) == 0);
      rw = 1'($urandom_range(0, 1));
      a  = $urandom;
      d  = $urandom;
      if (s && st[n] == 0) begin
        st[n] = 1; m_rw[n] = rw; m_addr[n] = a; m_wd[n] = d;
      end
      if (n == 0) begin
        c0_start = s; c0_rw = rw; c0_addr = a; c0_wdata = d;
      end else begin
        c1_start = s; c1_rw = rw; c1_addr = a; c1_wdata = d;
      end
    end
    eng_lat  = $urandom_range(1, 4);
    nx_wresp = 2'($urandom_range(0, 3));
    nx_rresp = 2'($urandom_range(0, 3));
    nx_rdata = $urandom;
  endtask

  initial begin
    int n0, d0;
    rst = 1'b1;
    c0_start = 1'b0; c0_rw = 1'b0; c0_addr = '0; c0_wdata = '0;
    c1_start = 1'b0; c1_rw = 1'b0; c1_addr = '0; c1_wdata = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // c0 write, latency and single pulse
    eng_lat = 3; nx_wresp = 2'd0;
    drive_start(0, 1'b1, 32'h1014, 32'h42);
    chk("t1_busy_after_accept", c0_busy, 1);
    chk("t1_no_early_pulse", amci_write, 0);
    @(negedge clk);
    chk("t1_write_pulse", amci_write, 1);
    chk("t1_no_read", amci_read, 0);
    chk("t1_waddr", amci_waddr, 32'h1014);
    chk("t1_wdata", amci_wdata, 32'h42);
    @(negedge clk);
    chk("t1_pulse_one_cycle", amci_write, 0);
    wait_done(0, "t1_done");
    chk("t1_resp", c0_resp, 0);
    chk("t1_busy_low_in_done", c0_busy, 0);
    chk("t1_rdata_untouched", c0_rdata, 0);
    @(negedge clk);
    chk("t1_done_one_cycle", c0_done, 0);
    chk("t1_log_size", log_addr.size(), 1);

    // c1 read with error response
    nx_rdata = 32'hDEADBEEF; nx_rresp = 2'd2;
    drive_start(1, 1'b0, 32'h1000, 32'h0);
    @(negedge clk);
    chk("t2_read_pulse", amci_read, 1);
    chk("t2_no_write", amci_write, 0);
    chk("t2_raddr", amci_raddr, 32'h1000);
    wait_done(1, "t2_done");
    chk("t2_rdata", c1_rdata, 32'hDEADBEEF);
    chk("t2_resp", c1_resp, 2);
    @(negedge clk);
    chk("t2_done_one_cycle", c1_done, 0);
    chk("t2_log_size", log_addr.size(), 2);

    // simultaneous starts, twice: c0, c1, c0, c1
    n0 = log_addr.size();
    nx_rdata = 32'h11112222; nx_rresp = 2'd0; nx_wresp = 2'd1;
    @(negedge clk);
    c0_start = 1'b1; c0_rw = 1'b0; c0_addr = 32'hA0;
    c1_start = 1'b1; c1_rw = 1'b1; c1_addr = 32'hB0; c1_wdata = 32'h77;
    @(negedge clk);
    c0_start = 1'b0; c1_start = 1'b0;
    wait_counts(dc0 + 1, dc1 + 1, "t3_round1");
    @(negedge clk);
    c0_start = 1'b1; c0_rw = 1'b1; c0_addr = 32'hA4; c0_wdata = 32'h55;
    c1_start = 1'b1; c1_rw = 1'b1; c1_addr = 32'hB4; c1_wdata = 32'h66;
    @(negedge clk);
    c0_start = 1'b0; c1_start = 1'b0;
    wait_counts(dc0 + 1, dc1 + 1, "t3_round2");
    chk("t3_log_size", log_addr.size(), n0 + 4);
    chk("t3_order0", log_addr[n0], 32'hA0);
    chk("t3_order1", log_addr[n0 + 1], 32'hB0);
    chk("t3_order2", log_addr[n0 + 2], 32'hA4);
    chk("t3_order3", log_addr[n0 + 3], 32'hB4);
    chk("t3_c0_rdata_kept", c0_rdata, 32'h11112222);
    chk("t3_c1_rdata_kept", c1_rdata, 32'hDEADBEEF);
    chk("t3_c0_resp", c0_resp, 1);
    chk("t3_no_overlap", overlap, 0);

    // second start while busy is ignored
    n0 = log_addr.size();
    @(negedge clk);
    c0_start = 1'b1; c0_rw = 1'b1; c0_addr = 32'h200; c0_wdata = 32'h5;
    @(negedge clk);
    c0_addr = 32'h300; c0_wdata = 32'h6;
    @(negedge clk);
    c0_start = 1'b0;
    wait_done(0, "t4_done");
    repeat (5) @(negedge clk);
    chk("t4_log_size", log_addr.size(), n0 + 1);
    chk("t4_addr", log_addr[n0], 32'h200);
    chk("t4_data", log_data[n0], 32'h5);
    chk("t4_busy_clear", c0_busy, 0);

    // reset while waiting on the engine
    eng_lat = 20;
    n0 = log_addr.size();
    d0 = dc0;
    drive_start(0, 1'b1, 32'h400, 32'h7);
    @(negedge clk);
    chk("t5_write_pulse", amci_write, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("t5_reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    #1;
    chk("t5_no_done", dc0, d0);
    chk("t5_busy_low", c0_busy, 0);
    chk("t5_no_reissue", log_addr.size(), n0 + 1);
    eng_lat = 2; nx_rdata = 32'hCAFE0001; nx_rresp = 2'd1;
    drive_start(1, 1'b0, 32'h500, 32'h0);
    @(negedge clk);
    chk("t5_post_read_pulse", amci_read, 1);
    chk("t5_post_raddr", amci_raddr, 32'h500);
    wait_done(1, "t5_post_done");
    chk("t5_post_rdata", c1_rdata, 32'hCAFE0001);
    chk("t5_post_resp", c1_resp, 1);

    // randomized traffic against the reference model
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 2; n++) begin
      st[n] = 0; m_rdata[n] = '0; m_resp[n] = '0;
      m_rw[n] = 1'b0; m_addr[n] = '0; m_wd[n] = '0;
    end
    m_last = 1;
    m_svc = -1;
    repeat (600) model_step(1'b1);
    repeat (60) model_step(1'b0);
    chk("rnd_drained_c0", st[0], 0);
    chk("rnd_drained_c1", st[1], 0);
    chk("rnd_no_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
